// File: rtl/mem_arbiter_pkg.sv
// Shared codes for the IF/MEM SRAM arbiter: rwe op codes, FSM state encodings
// and grant-owner identifiers.
package mem_arbiter_pkg;

    localparam logic [1:0] RWE_NONE  = 2'b00;
    localparam logic [1:0] RWE_READ  = 2'b01;
    localparam logic [1:0] RWE_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_IF   = 2'b01,
        OWNER_MEM  = 2'b10
    } owner_t;

    // Code 11 is reserved and must not count as a request.
    function automatic logic rwe_is_request(input logic [1:0] rwe);
        return (rwe == RWE_READ) || (rwe == RWE_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes (IF and MEM ports) and the shared SRAM bus
// seen by mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic               if_req;
    logic [15:0]        if_addr;
    logic               if_ack;
    logic [15:0]        if_rdata;

    logic [1:0]         mem_rwe;
    logic [15:0]        mem_addr;
    logic [15:0]        mem_wdata;
    logic               mem_ack;
    logic [15:0]        mem_rdata;

    logic               stall_if;
    logic               stall_mem;

    logic [ADDR_W-1:0]  sram_addr;
    logic [15:0]        sram_wdata;
    logic               sram_data_oe;
    logic [15:0]        sram_rdata;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    modport slave (
        input  if_req, if_addr, mem_rwe, mem_addr, mem_wdata, sram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
        output sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output if_req, if_addr, mem_rwe, mem_addr, mem_wdata, sram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
        input  sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/mem_arbiter_sram_timing.sv
// SRAM access timing: counts the WAIT_CYCLES of an access and derives the
// active-low strobes and bus drive enable from the op and remaining count.
module mem_arbiter_sram_timing #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_access,
    input  logic is_write,
    output logic cnt_last,
    output logic ce_n,
    output logic oe_n,
    output logic we_n,
    output logic data_oe
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= CNT_INIT;
        end else if (in_access && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign cnt_last = (cnt == 4'd0);

    // we_n rises one cycle before the access ends so address/data are held
    // stable across the write-enable release.
    assign ce_n    = ~in_access;
    assign oe_n    = ~(in_access && !is_write);
    assign we_n    = ~(in_access && is_write && !cnt_last);
    assign data_oe = in_access && is_write;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one SRAM between instruction fetch and data access; MEM has
// priority. Optional IF anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES  = 2,
    parameter int ADDR_W       = 18,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || ADDR_W < 16)
    begin : g_param_check
        $error("mem_arbiter: parameter out of range");
    end

    arb_state_t         state, state_n;
    owner_t             owner;
    logic               op_write;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        wdata_q;
    logic [15:0]        if_rdata_q;
    logic [15:0]        mem_rdata_q;

    logic               mem_valid;
    logic               if_wins;
    logic               starve_force;
    logic               grant_if;
    logic               grant_mem;
    logic               in_access;
    logic               cnt_last;

    assign mem_valid = rwe_is_request(bus.mem_rwe);
    assign if_wins   = bus.if_req && (!mem_valid || starve_force);
    assign in_access = (state == ARB_ACCESS);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Counts MEM grants that left a pending fetch waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_if) begin
            starve_cnt <= 4'd0;
        end else if (grant_mem && bus.if_req && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign starve_force = (starve_cnt == 4'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (if_wins) begin
                    grant_if = 1'b1;
                    state_n  = ARB_ACCESS;
                end else if (mem_valid) begin
                    grant_mem = 1'b1;
                    state_n   = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_last) begin
                    state_n = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // Request fields are captured once at grant; later changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= OWNER_NONE;
            op_write    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'd0;
            if_rdata_q  <= 16'd0;
            mem_rdata_q <= 16'd0;
        end else begin
            if (grant_if) begin
                owner    <= OWNER_IF;
                op_write <= 1'b0;
                addr_q   <= ADDR_W'(bus.if_addr);
            end else if (grant_mem) begin
                owner    <= OWNER_MEM;
                op_write <= (bus.mem_rwe == RWE_WRITE);
                addr_q   <= ADDR_W'(bus.mem_addr);
                wdata_q  <= bus.mem_wdata;
            end
            if (in_access && cnt_last && !op_write) begin
                if (owner == OWNER_IF) begin
                    if_rdata_q <= bus.sram_rdata;
                end else if (owner == OWNER_MEM) begin
                    mem_rdata_q <= bus.sram_rdata;
                end
            end
        end
    end

    mem_arbiter_sram_timing #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .start     (grant_if || grant_mem),
        .in_access (in_access),
        .is_write  (op_write),
        .cnt_last  (cnt_last),
        .ce_n      (bus.sram_ce_n),
        .oe_n      (bus.sram_oe_n),
        .we_n      (bus.sram_we_n),
        .data_oe   (bus.sram_data_oe)
    );

    assign bus.if_ack     = (state == ARB_DONE) && (owner == OWNER_IF);
    assign bus.mem_ack    = (state == ARB_DONE) && (owner == OWNER_MEM);
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.stall_if   = bus.if_req && !bus.if_ack;
    assign bus.stall_mem  = mem_valid && !bus.mem_ack;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;

endmodule
